// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int PORT_CORE   = 0;
    localparam int PORT_LOADER = 1;

    // Watchdog counter width: wide enough for the limit, kept within 8..16 bits.
    function automatic int timeout_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) begin
            w = 8;
        end
        if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Combinational two-way round-robin pick; the port that was not
//            served last wins a tie. Output is one-hot (or zero).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter/sequencer for the single data-memory port.
//            Optional WAIT watchdog enabled by DMEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_miss
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic       r_last;
    logic       r_win;
    logic       r_we;
    logic [1:0] w_pick;
    logic       w_pick_idx;
    logic       w_start;
    logic       w_finish;
    logic       w_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dmem_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    rr_arbiter2 u_rr (
        .req  (req_i),
        .last (r_last),
        .gnt  (w_pick)
    );

    assign w_pick_idx = w_pick[PORT_LOADER];
    assign w_start    = (r_state == IDLE) && (w_state_nxt == ISSUE);
    assign w_finish   = (r_state == WAIT) && (w_state_nxt == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt_o       = 2'b00;
        done_o      = 2'b00;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|w_pick) && mem_ready) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt_o[r_win] = 1'b1;
                mem_we       = r_we;
                mem_re       = ~r_we;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                if (!mem_miss || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done_o[r_win] = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command fields are captured as ISSUE is entered, so the requester is
    // free to move on once it sees its grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win     <= 1'b0;
            r_we      <= 1'b0;
            r_last    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_o   <= '0;
        end else begin
            if (w_start) begin
                r_win     <= w_pick_idx;
                r_we      <= we_i[w_pick_idx];
                mem_addr  <= w_pick_idx ? addr1_i : addr0_i;
                mem_wdata <= w_pick_idx ? wdata1_i : wdata0_i;
            end
            if (r_state == ISSUE) begin
                r_last <= r_win;
            end
            if (w_finish) begin
                if (w_timeout) begin
                    rdata_o <= '0;
                end else if (!r_we) begin
                    rdata_o <= mem_rdata;
                end
            end
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

    // r_cnt holds the number of cycles elapsed since ISSUE.
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_err <= w_timeout;
            end
        end
    end

    assign w_timeout = (r_state == WAIT) && mem_miss &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_o     = (r_state == DONE) && r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed scoreboard bench for dmem_arbiter with a small memory
//            responder; covers the timeout path when DMEM_ARB_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [31:0] addr0_i;
    logic [31:0] addr1_i;
    logic [31:0] wdata0_i;
    logic [31:0] wdata1_i;
    logic [1:0]  gnt_o;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_miss;

    dmem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr0_i   (addr0_i),
        .addr1_i   (addr1_i),
        .wdata0_i  (wdata0_i),
        .wdata1_i  (wdata1_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_miss  (mem_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [1:0]  gq[$];
    int          gcyc[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          miss_len  = 0;
    int          miss_left = 0;
    int          we_cnt = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;
    logic [1:0]  hold = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: monitor grants/stores/completions, then update the memory responder.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (gnt_o != 2'b00) begin
            gq.push_back(gnt_o);
            gcyc.push_back(cyc);
            miss_left = miss_len;
        end
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
        if (done_o != 2'b00) begin
            if (sbq.size() == 0) begin
                check("done_unexpected", {30'd0, done_o}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("done_port", {30'd0, done_o}, {30'd0, e.port});
                check("done_rdata", rdata_o, e.rdata);
                check("done_err", {31'd0, err_o}, {31'd0, e.err});
                if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
            end
            req_i = req_i & ~(done_o & ~hold);
        end
        if (gnt_o == 2'b00 && miss_left > 0) begin
            mem_miss = 1'b1;
            miss_left--;
        end else begin
            mem_miss = 1'b0;
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic push_exp(input logic [1:0] port, input logic [31:0] rdata,
                            input logic err, input int at);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = at;
        sbq.push_back(e);
    endtask

    int   c;
    int   n;
    logic stall;

    initial begin
        rstn = 1'b0; req_i = 2'b00; we_i = 2'b00;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        mem_rdata = '0; mem_ready = 1'b1; mem_miss = 1'b0;
        step();
        step();
        check("rst_ctrl", {25'd0, gnt_o, done_o, err_o, mem_we, mem_re}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rstn = 1'b1;
        step();

        // Port 0 load with three miss cycles
        miss_len = 3; mem_rdata = 32'hDEAD_BEEF;
        c = cyc; req_i = 2'b01; we_i = 2'b00; addr0_i = 32'h40;
        push_exp(2'b01, 32'hDEAD_BEEF, 1'b0, c + 6);
        step();
        check("t1_gnt", {30'd0, gnt_o}, 32'd1);
        check("t1_cmd", {30'd0, mem_we, mem_re}, 32'd1);
        check("t1_addr", mem_addr, 32'h40);
        addr0_i = 32'hBAD0;
        step();
        check("t1_addr_held", mem_addr, 32'h40);
        check("t1_cmd_off", {30'd0, mem_we, mem_re}, 32'd0);
        drain(20);
        step();

        // Port 1 store, no miss; rdata_o must keep the previous load value
        miss_len = 0; mem_rdata = 32'h0BAD_F00D; we_cnt = 0;
        c = cyc; req_i = 2'b10; we_i = 2'b10;
        addr1_i = 32'h100; wdata1_i = 32'h1234_5678;
        push_exp(2'b10, 32'hDEAD_BEEF, 1'b0, c + 3);
        drain(20);
        check("t2_we_cnt", we_cnt, 32'd1);
        check("t2_we_addr", we_addr, 32'h100);
        check("t2_we_data", we_data, 32'h1234_5678);
        step();

        // mem_ready low stalls the request in IDLE
        mem_ready = 1'b0; we_i = 2'b00; addr0_i = 32'h80; req_i = 2'b01; stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            stall = stall | (gnt_o != 2'b00) | mem_re;
        end
        check("t3_stall", {31'd0, stall}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0080; miss_len = 1; c = cyc;
        push_exp(2'b01, 32'hCAFE_0080, 1'b0, c + 4);
        step();
        check("t3_gnt", {30'd0, gnt_o}, 32'd1);
        check("t3_addr", mem_addr, 32'h80);
        drain(20);
        step();

        // Asynchronous reset in WAIT aborts the transaction
        miss_len = 6; addr0_i = 32'h44; req_i = 2'b01;
        step();
        check("t4_gnt", {30'd0, gnt_o}, 32'd1);
        step();
        step();
        #2 rstn = 1'b0;
        #1;
        check("t4_rst_ctrl", {25'd0, gnt_o, done_o, err_o, mem_we, mem_re}, 32'd0);
        check("t4_rst_rdata", rdata_o, 32'd0);
        check("t4_rst_addr", mem_addr, 32'd0);
        step();
        step();
        miss_left = 0; miss_len = 2; mem_rdata = 32'h600D_0044;
        rstn = 1'b1; c = cyc;
        push_exp(2'b01, 32'h600D_0044, 1'b0, c + 5);
        drain(20);
        step();

        // Fresh reset, then both ports held: grants must alternate from port 0
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        hold = 2'b11; miss_len = 0; mem_rdata = 32'h1111_2222;
        we_i = 2'b00; addr0_i = 32'h10; addr1_i = 32'h20;
        gq.delete(); gcyc.delete();
        for (int k = 0; k < 5; k++) begin
            push_exp((k % 2 == 0) ? 2'b01 : 2'b10, 32'h1111_2222, 1'b0, -1);
        end
        req_i = 2'b11;
        n = 0;
        while (gq.size() < 4 && n < 40) begin
            step();
            n++;
        end
        hold = 2'b00;
        drain(40);
        check("t5_ngnt", gq.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) begin
                check("t5_gnt_order", {30'd0, gq[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
            end
        end
        if (gcyc.size() > 1) check("t5_b2b_gap", gcyc[1] - gcyc[0], 32'd4);
        step();

        // Long miss: watchdog abort when enabled, unbounded wait otherwise
        addr0_i = 32'h48; mem_rdata = 32'h7777_0048; req_i = 2'b01; c = cyc;
`ifdef DMEM_ARB_TIMEOUT_EN
        miss_len = 100;
        push_exp(2'b01, 32'd0, 1'b1, c + 11);
`else
        miss_len = 20;
        push_exp(2'b01, 32'h7777_0048, 1'b0, c + 23);
`endif
        drain(60);
        step();

        // Block must be back in IDLE and serve a new request at minimum latency
        miss_len = 0; mem_rdata = 32'h8888_0200; addr1_i = 32'h200;
        req_i = 2'b10; c = cyc;
        push_exp(2'b10, 32'h8888_0200, 1'b0, c + 3);
        drain(20);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
